sram_dp_be: RTL and testbench

Simple dual-port (one write, one read) synchronous SRAM with per-byte write enables, selectable read-during-write behaviour, a registered read port with valid flag and a built-in clear sequencer. It is the parametrised successor to the team's single-port 6-bit/8-bit RAM. It is the standard on-chip storage primitive for buffers and lookup tables that need concurrent producer/consumer access.

---
 rtl/sram_pkg.sv | 34 +++
 rtl/sram_clear_seq.sv | 86 ++++++++
 rtl/sram_dp_be_chk.sv | 20 ++
 rtl/sram_dp_be.sv | 150 +++++++++++++++
 tb/tb_sram_dp_be.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port byte-enable SRAM: read-during-write
// modes, sequencer state encoding and the byte-lane merge used by both write and bypass.
package sram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_MAX_W  = 1024;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } sram_state_e;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: owns the CLEAR/IDLE FSM, the clear pointer and busy, and
// drives a full-word write override into the array while clearing.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    clr_en,
  output logic [ADDR_WIDTH-1:0]   clr_addr,
  output logic [DATA_WIDTH-1:0]   clr_data,
  output logic [DATA_WIDTH/8-1:0] clr_be
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  sram_state_e           state_r;
  sram_state_e           state_nxt_s;
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH-1:0] ptr_nxt_s;
  logic                  busy_r;

  // State, clear pointer and busy flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= {ADDR_WIDTH{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
    end
  end

  // Next state: sweep the pointer while clearing; clr_req restarts only from IDLE
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = ptr_r + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        ptr_nxt_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Write-port override presented to the array
  always_comb begin
    clr_addr = ptr_r;
    clr_data = INIT_VALUE;
    clr_be   = {(DATA_WIDTH/8){1'b1}};
    if (state_r == ST_CLEAR) begin
      clr_en = 1'b1;
    end else begin
      clr_en = 1'b0;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/sram_dp_be_chk.sv
// Protocol checks on the read port: rd_valid only follows an accepted read,
// and rd_data never moves without rd_valid.
module sram_dp_be_chk #(
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  rd_en,
  input logic                  busy,
  input logic                  rd_valid,
  input logic [DATA_WIDTH-1:0] rd_data
);

  a_valid_cause: assert property (@(posedge clk) disable iff (!rst_n)
    rd_valid |-> $past(rd_en && !busy));

  a_data_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !rd_valid |-> $stable(rd_data));

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with per-byte write enables, registered read port,
// selectable read-during-write behaviour and a built-in clear sequencer.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    RDW_MODE   = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  busy_s;
  logic                  clr_en_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic [DATA_WIDTH-1:0] clr_data_s;
  logic [BE_W-1:0]       clr_be_s;

  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;

  logic                  port_en_s;
  logic [ADDR_WIDTH-1:0] port_addr_s;
  logic [DATA_WIDTH-1:0] port_data_s;
  logic [BE_W-1:0]       port_be_s;

  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    return DATA_WIDTH'(byte_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                                  MERGE_MAX_BE'(be)));
  endfunction

  sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy_s),
    .clr_en   (clr_en_s),
    .clr_addr (clr_addr_s),
    .clr_data (clr_data_s),
    .clr_be   (clr_be_s)
  );

  // A fully populated address space has no out-of-range addresses to filter
  if (DEPTH < (1 << ADDR_WIDTH)) begin : g_range_chk
    assign wr_in_range_s = (wr_addr < ADDR_WIDTH'(DEPTH));
    assign rd_in_range_s = (rd_addr < ADDR_WIDTH'(DEPTH));
  end else begin : g_range_full
    assign wr_in_range_s = 1'b1;
    assign rd_in_range_s = 1'b1;
  end

  // A clear request in IDLE takes priority over a same-cycle user write
  assign wr_accept_s = wr_en && !busy_s && !clr_req && wr_in_range_s;
  assign rd_accept_s = rd_en && !busy_s;

  // Single array write port: the clear sequencer overrides user writes
  always_comb begin
    if (clr_en_s) begin
      port_en_s   = 1'b1;
      port_addr_s = clr_addr_s;
      port_data_s = clr_data_s;
      port_be_s   = clr_be_s;
    end else begin
      port_en_s   = wr_accept_s;
      port_addr_s = wr_addr;
      port_data_s = wr_data;
      port_be_s   = wr_be;
    end
  end

  // Array write; the storage itself is deliberately not reset
  always_ff @(posedge clk) begin
    if (port_en_s) begin
      mem_r[port_addr_s] <= merge_word(mem_r[port_addr_s], port_data_s, port_be_s);
    end
  end

  // Read word selection, including write-first bypass of a same-address write
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (!rd_in_range_s) begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end else if ((RDW_MODE == RDW_WRITE_FIRST) && wr_accept_s && (wr_addr == rd_addr)) begin
      rd_word_s = merge_word(mem_r[rd_addr], wr_data, wr_be);
    end else begin
      rd_word_s = mem_r[rd_addr];
    end
  end

  // Registered read port; data holds whenever no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_s;

  sram_dp_be_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .busy     (busy_s),
    .rd_valid (rd_valid_r),
    .rd_data  (rd_data_r)
  );

endmodule

// File: tb/tb_sram_dp_be.sv
// Self-checking bench: three SRAM configurations share one random/directed
// stimulus stream and are compared every cycle against a behavioural model.
module tb_sram_dp_be;

  localparam int NI = 3;
  localparam int DEP [NI] = '{64, 64, 48};
  localparam int RDW [NI] = '{0, 1, 0};
  localparam logic [31:0] INI [NI] = '{32'h0000_0000, 32'h5A5A_5A5A, 32'h0000_0000};

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        clr_req;
  logic [31:0] rd_data_o  [NI];
  logic        rd_valid_o [NI];
  logic        busy_o     [NI];

  int checks;
  int failures;

  // model state
  logic [31:0] mm [NI][64];
  int          clr_left [NI];
  logic [31:0] e_data [NI];
  logic        e_valid [NI];
  int          bcnt [NI];

  sram_dp_be #(.RDW_MODE(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
    .rd_valid(rd_valid_o[0]), .clr_req(clr_req), .busy(busy_o[0]));

  sram_dp_be #(.RDW_MODE(1), .INIT_VALUE(32'h5A5A_5A5A)) u_wf (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
    .rd_valid(rd_valid_o[1]), .clr_req(clr_req), .busy(busy_o[1]));

  sram_dp_be #(.DEPTH(48)) u_oor (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]),
    .rd_valid(rd_valid_o[2]), .clr_req(clr_req), .busy(busy_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: a clear is just "N words left to initialise"
  initial begin
    logic [31:0] v;
    logic        wok;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          clr_left[k] = DEP[k];
          e_data[k]   = 32'h0;
          e_valid[k]  = 1'b0;
        end else if (clr_left[k] > 0) begin
          mm[k][DEP[k] - clr_left[k]] = INI[k];
          clr_left[k] = clr_left[k] - 1;
          e_valid[k]  = 1'b0;
        end else begin
          wok = wr_en && !clr_req && (int'(wr_addr) < DEP[k]);
          if (rd_en) begin
            if (int'(rd_addr) >= DEP[k]) begin
              v = 32'h0;
            end else begin
              v = mm[k][rd_addr];
              if (RDW[k] == 1 && wok && wr_addr == rd_addr) v = merge(v, wr_data, wr_be);
            end
            e_data[k]  = v;
            e_valid[k] = 1'b1;
          end else begin
            e_valid[k] = 1'b0;
          end
          if (wok) mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_be);
          if (clr_req) clr_left[k] = DEP[k];
        end
      end
    end
  end

  // Cycle-by-cycle compare of every instance against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < NI; k++) begin
          chk($sformatf("busy_u%0d", k), {31'h0, busy_o[k]}, {31'h0, clr_left[k] > 0});
          chk($sformatf("rd_valid_u%0d", k), {31'h0, rd_valid_o[k]}, {31'h0, e_valid[k]});
          chk($sformatf("rd_data_u%0d", k), rd_data_o[k], e_data[k]);
        end
      end
    end
  end

  task automatic step(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [5:0] ra,
                      input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = cr;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic count_busy();
    for (int k = 0; k < NI; k++) bcnt[k] = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) if (bcnt[k] < 0 && !busy_o[k]) bcnt[k] = e;
      if (bcnt[0] >= 0 && bcnt[1] >= 0 && bcnt[2] >= 0) break;
    end
    for (int k = 0; k < NI; k++) chk($sformatf("busy_edges_u%0d", k), bcnt[k], DEP[k]);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_data_u%0d", tag, k), rd_data_o[k], 32'h0);
      chk($sformatf("%s_valid_u%0d", tag, k), {31'h0, rd_valid_o[k]}, 32'h0);
      chk($sformatf("%s_busy_u%0d", tag, k), {31'h0, busy_o[k]}, 32'h1);
    end
  endtask

  initial begin
    int cnt;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = 6'd0; wr_data = 32'h0; wr_be = 4'h0;
    rd_en = 1'b0; rd_addr = 6'd0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    count_busy();

    // post-reset reads: 63 is out of range for the 48-deep instance
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd0, 1'b0);
    chk("rd0_wf", rd_data_o[1], 32'h5A5A_5A5A);
    chk("rd0_valid_rf", {31'h0, rd_valid_o[0]}, 32'h1);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd31, 1'b0);
    chk("rd31_rf", rd_data_o[0], 32'h0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd63, 1'b0);
    chk("rd63_wf", rd_data_o[1], 32'h5A5A_5A5A);
    chk("rd63_oor_valid", {31'h0, rd_valid_o[2]}, 32'h1);

    // byte enables
    step(1'b1, 6'd5, 32'hAABB_CCDD, 4'b1111, 1'b0, 6'd0, 1'b0);
    step(1'b1, 6'd5, 32'h1122_3344, 4'b0101, 1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd5, 1'b0);
    for (int k = 0; k < NI; k++) chk($sformatf("be_merge_u%0d", k), rd_data_o[k], 32'hAA22_CC44);

    // read-during-write on addr 9
    step(1'b1, 6'd9, 32'hDEAD_BEEF, 4'b1111, 1'b1, 6'd9, 1'b0);
    chk("rdw_read_first", rd_data_o[0], 32'h0);
    chk("rdw_write_first", rd_data_o[1], 32'hDEAD_BEEF);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd9, 1'b0);
    chk("rdw_next_rf", rd_data_o[0], 32'hDEAD_BEEF);
    chk("rdw_next_wf", rd_data_o[1], 32'hDEAD_BEEF);

    // out of range on the 48-deep instance
    step(1'b1, 6'd50, 32'h1234_5678, 4'b1111, 1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd50, 1'b0);
    chk("oor_rd_data", rd_data_o[2], 32'h0);
    chk("oor_rd_valid", {31'h0, rd_valid_o[2]}, 32'h1);
    chk("inrange_rd50", rd_data_o[0], 32'h1234_5678);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd2, 1'b0);
    chk("oor_alias2", rd_data_o[2], 32'h0);

    // fill, then clear together with a write to addr 3
    for (int a = 0; a < 64; a++) step(1'b1, 6'(a), $urandom, 4'b1111, 1'b0, 6'd0, 1'b0);
    step(1'b1, 6'd3, 32'hCAFE_F00D, 4'b1111, 1'b0, 6'd0, 1'b1);
    cnt = 0;
    while (busy_o[1] && cnt < 200) begin
      step(1'b1, 6'($urandom_range(0, 63)), $urandom, 4'hF, 1'b1, 6'($urandom_range(0, 63)), 1'b0);
      if (cnt == 0) chk("busy_rd_valid_wf", {31'h0, rd_valid_o[1]}, 32'h0);
      cnt++;
    end
    chk("clr_busy_cycles", cnt, 64);
    for (int a = 0; a < 64; a++) begin
      step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'(a), 1'b0);
      if (a == 3) chk("clr_addr3_wf", rd_data_o[1], 32'h5A5A_5A5A);
      if (a == 40) chk("clr_addr40_wf", rd_data_o[1], 32'h5A5A_5A5A);
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] wa;
      wa = 6'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, wa, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63)),
           $urandom_range(0, 299) == 0);
    end
    cnt = 0;
    while (busy_o[1] && cnt < 200) begin
      step(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0);
      cnt++;
    end

    // asynchronous reset mid-traffic, then mid-clear
    step(1'b1, 6'd7, 32'h0BAD_F00D, 4'b1111, 1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd7, 1'b0);
    chk("pre_reset_data_rf", rd_data_o[0], 32'h0BAD_F00D);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_traffic");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) step(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_clear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy();
    step(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd7, 1'b0);
    chk("post_reset_rd7_wf", rd_data_o[1], 32'h5A5A_5A5A);
    chk("post_reset_rd7_rf", rd_data_o[0], 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
